// File: rtl/dma_line_copier.sv
// Multi-line DMA copy engine: reads each line from src into a local buffer, then
// writes it to dst, stepping both addresses by one line stride per line.
module dma_line_copier #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 64,
  parameter int LINES_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LINES_W-1:0] num_lines,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic [1:0]        op,
  output logic [ADDR_W-1:0] io_address,
  input  logic              tx_done,
  input  logic              rd_valid,
  input  logic              wr_ready,
  input  logic [DATA_W-1:0] common_data_bus_in,
  output logic [DATA_W-1:0] common_data_bus_out
);

  localparam int CW = $clog2(LINE_WORDS) + 1;
  localparam logic [CW-1:0]     LW_C     = CW'(LINE_WORDS);
  localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(LINE_WORDS * (DATA_W / 8));

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_PRIME = 3'd2;
  localparam logic [2:0] S_WR       = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b11;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [LINES_W-1:0] num_q, num_d;
  logic [LINES_W-1:0] line_cnt_q, line_cnt_d;
  logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]      wr_idx_q, wr_idx_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               buf_we_s;
  logic [DATA_W-1:0]  buf_q [LINE_WORDS];
  logic [DATA_W-1:0]  bus_out_s;

  // Next-state logic: src_q/dst_q always hold the current line's addresses.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    num_d      = num_q;
    line_cnt_d = line_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_idx_d   = wr_idx_q;
    err_d      = err_q;
    buf_we_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d      = src_addr;
          dst_d      = dst_addr;
          num_d      = num_lines;
          err_d      = 1'b0;
          line_cnt_d = '0;
          rd_cnt_d   = '0;
          state_d    = (num_lines == '0) ? S_DONE : S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (rd_valid) begin
          if (rd_cnt_q < LW_C) begin
            buf_we_s = 1'b1;
            rd_cnt_d = rd_cnt_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
        if (tx_done) begin
          state_d = S_WR_PRIME;
        end else begin
          state_d = S_RD;
        end
      end
      S_WR_PRIME: begin
        wr_idx_d = '0;
        state_d  = S_WR;
      end
      S_WR: begin
        if (tx_done) begin
          rd_cnt_d   = '0;
          line_cnt_d = line_cnt_q + LINES_W'(1);
          src_d      = src_q + STRIDE_C;
          dst_d      = dst_q + STRIDE_C;
          state_d    = (line_cnt_q + LINES_W'(1) == num_q) ? S_DONE : S_RD;
        end else if (wr_ready && (wr_idx_q < rd_cnt_q)) begin
          wr_idx_d = wr_idx_q + CW'(1);
        end else begin
          wr_idx_d = wr_idx_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    op_d   = OP_IDLE;
    addr_d = '0;
    case (state_d)
      S_RD: begin
        op_d   = OP_READ;
        addr_d = src_d;
      end
      S_WR_PRIME, S_WR: begin
        op_d   = OP_WRITE;
        addr_d = dst_d;
      end
      default: begin
        op_d   = OP_IDLE;
        addr_d = '0;
      end
    endcase
    busy_d = (state_d == S_RD) || (state_d == S_WR_PRIME) || (state_d == S_WR);
    done_d = (state_d == S_DONE);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      num_q      <= '0;
      line_cnt_q <= '0;
      rd_cnt_q   <= '0;
      wr_idx_q   <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_q       <= OP_IDLE;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      num_q      <= num_d;
      line_cnt_q <= line_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_idx_q   <= wr_idx_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
    end
  end

  // Line buffer capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        buf_q[i] <= '0;
      end
    end else if (buf_we_s) begin
      buf_q[rd_cnt_q[CW-2:0]] <= common_data_bus_in;
    end
  end

  // Write data: slots past the captured count read as zero on a short line.
  always_comb begin
    bus_out_s = '0;
    if (state_q == S_WR_PRIME) begin
      bus_out_s = buf_q[0];
    end else if ((state_q == S_WR) && (wr_idx_q < rd_cnt_q)) begin
      bus_out_s = buf_q[wr_idx_q[CW-2:0]];
    end else begin
      bus_out_s = '0;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign err_ovf             = err_q;
  assign op                  = op_q;
  assign io_address          = addr_q;
  assign common_data_bus_out = bus_out_s;

endmodule

// File: tb/tb_dma_line_copier.sv
// Randomized self-checking bench: plays the memory controller and predicts
// addresses, write data, done and err_ovf from a per-line word-list model.
module tb_dma_line_copier;
  localparam int DATA_W = 32;
  localparam int LW     = 16;
  localparam int ADDR_W = 64;
  localparam int LINES_W = 16;
  localparam logic [63:0] STRIDE = 64'(LW * DATA_W / 8);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0, dst_addr = '0;
  logic [LINES_W-1:0] num_lines = '0;
  logic busy, done, err_ovf;
  logic [1:0] op;
  logic [ADDR_W-1:0] io_address;
  logic tx_done = 1'b0, rd_valid = 1'b0, wr_ready = 1'b0;
  logic [DATA_W-1:0] bus_in = '0;
  logic [DATA_W-1:0] bus_out;

  int n_cmp = 0;
  int n_err = 0;
  int nw_q[$];

  dma_line_copier #(.DATA_W(DATA_W), .LINE_WORDS(LW), .ADDR_W(ADDR_W), .LINES_W(LINES_W)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_lines(num_lines), .busy(busy), .done(done), .err_ovf(err_ovf), .op(op),
    .io_address(io_address), .tx_done(tx_done), .rd_valid(rd_valid), .wr_ready(wr_ready),
    .common_data_bus_in(bus_in), .common_data_bus_out(bus_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One job: the bench drives the bus, the model is a list of words per line.
  task automatic run_job(input logic [63:0] src, input logic [63:0] dst, input int n,
                         input bit seq, input bit disturb);
    logic [63:0] s_a, d_a;
    logic [31:0] words[$];
    int nw, i, j, cnt;
    bit ovf, sent;
    ovf = 1'b0;
    @(negedge clk);
    start = 1'b1; src_addr = src; dst_addr = dst; num_lines = LINES_W'(n);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      check("zero_done", done, 1); check("zero_op", op, 0);
      check("zero_busy", busy, 0); check("zero_err", err_ovf, 0);
      @(negedge clk);
      check("zero_done_pulse", done, 0); check("zero_op_after", op, 0);
      return;
    end
    s_a = src; d_a = dst;
    for (int k = 0; k < n; k++) begin
      nw = (nw_q.size() > 0) ? nw_q.pop_front() : int'($urandom_range(0, LW + 2));
      words.delete(); i = 0; sent = 1'b0;
      while (!sent) begin
        check("rd_op", op, 2'b01); check("rd_addr", io_address, s_a);
        check("rd_busy", busy, 1); check("rd_done", done, 0);
        rd_valid = 1'b0; tx_done = 1'b0;
        start = disturb && ($urandom_range(0, 3) == 0);
        src_addr = {$urandom, $urandom}; num_lines = LINES_W'($urandom);
        if (i < nw && (seq || $urandom_range(0, 3) != 0)) begin
          rd_valid = 1'b1;
          bus_in = seq ? 32'(i) : $urandom;
          words.push_back(bus_in);
          i++;
          if (i == nw && $urandom_range(0, 1) == 1) begin
            tx_done = 1'b1; sent = 1'b1;
          end
        end else if (i >= nw) begin
          tx_done = 1'b1; sent = 1'b1;
        end
        @(negedge clk);
      end
      rd_valid = 1'b0; tx_done = 1'b0; start = 1'b0;
      cnt = (nw > LW) ? LW : nw;
      if (nw > LW) ovf = 1'b1;
      check("prime_op", op, 2'b11); check("prime_addr", io_address, d_a);
      if (cnt > 0) check("prime_data", bus_out, words[0]);
      wr_ready = 1'($urandom); tx_done = 1'($urandom);
      @(negedge clk);
      j = 0; sent = 1'b0;
      while (!sent) begin
        check("wr_op", op, 2'b11); check("wr_addr", io_address, d_a);
        check("wr_data", bus_out, (j < cnt) ? 64'(words[j]) : 64'd0);
        check("wr_err", err_ovf, ovf);
        wr_ready = ($urandom_range(0, 2) != 0); tx_done = 1'b0;
        start = disturb && ($urandom_range(0, 3) == 0);
        if (j == cnt && $urandom_range(0, 1) == 1) begin
          tx_done = 1'b1; sent = 1'b1;
        end else if (wr_ready && j < cnt) begin
          j++;
        end
        @(negedge clk);
      end
      wr_ready = 1'b0; tx_done = 1'b0; start = 1'b0;
      s_a = s_a + STRIDE; d_a = d_a + STRIDE;
    end
    check("end_done", done, 1); check("end_busy", busy, 0);
    check("end_op", op, 0); check("end_err", err_ovf, ovf);
    @(negedge clk);
    check("end_done_pulse", done, 0); check("end_err_sticky", err_ovf, ovf);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_op", op, 0); check("rst_busy", busy, 0); check("rst_done", done, 0);
    check("rst_err", err_ovf, 0); check("rst_addr", io_address, 0); check("rst_bus", bus_out, 0);
    rst = 1'b0;

    // Reset asserted mid-read after five words.
    @(negedge clk);
    start = 1'b1; src_addr = 64'h1000; dst_addr = 64'h400; num_lines = 16'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_valid = 1'b1; bus_in = $urandom;
      @(negedge clk);
    end
    rd_valid = 1'b0;
    check("pre_rst_op", op, 2'b01);
    rst = 1'b1;
    #1;
    check("mid_rst_op", op, 0); check("mid_rst_busy", busy, 0); check("mid_rst_addr", io_address, 0);
    @(negedge clk);
    rst = 1'b0;

    nw_q = '{16};
    run_job(64'h1000, 64'h400, 1, 1'b1, 1'b0);
    nw_q = '{16, 16, 16};
    run_job(64'h0, 64'h8000, 3, 1'b0, 1'b0);
    nw_q = '{5, 17};
    run_job(64'h2000, 64'h3000, 2, 1'b0, 1'b0);
    check("ovf_held", err_ovf, 1);
    run_job(64'h5000, 64'h6000, 0, 1'b0, 1'b0);
    nw_q = '{0, 3};
    run_job(64'hFFFF_FFFF_FFFF_FFC0, 64'h100, 2, 1'b0, 1'b1);
    for (int t = 0; t < 8; t++) begin
      run_job({$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)), 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
